// File: rtl/if_id_buffer.sv
// if_id_buffer: two-entry skid buffer between instruction fetch and decode.
// Holds {pc, instr} pairs in FIFO order and presents the oldest to decode,
// with the instruction pre-split into Opcode/Funct3/Funct7 fields.
// in_ready and all out_* signals come from registers only, so neither
// out_ready nor flush has a combinational path back to fetch.
// Optional build macro IFID_NOP_BUBBLE_EN: when defined, out_instr shows
// NOP_INSTR whenever the buffer is empty.
module if_id_buffer #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  NOP_INSTR = 'h00000013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [6:0]      Opcode,
  output logic [2:0]      Funct3,
  output logic [6:0]      Funct7,
  output logic [1:0]      occupancy
);

  logic [XLEN-1:0] pc_q    [2];
  logic [XLEN-1:0] instr_q [2];
  logic            rp_q;
  logic            wp_q;
  logic [1:0]      count_q;
  logic [1:0]      count_d;
  logic            push;
  logic            pop;

  // Flush masks both handshakes so a redirect never admits or retires a pair.
  always_comb begin
    push    = in_valid & in_ready & ~flush;
    pop     = out_valid & out_ready & ~flush;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Pointer and occupancy state; flush empties the buffer in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp_q    <= 1'b0;
      wp_q    <= 1'b0;
      count_q <= 2'd0;
    end else if (flush) begin
      rp_q    <= 1'b0;
      wp_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) wp_q <= ~wp_q;
      if (pop)  rp_q <= ~rp_q;
      count_q <= count_d;
    end
  end

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (push) begin
      pc_q[wp_q]    <= in_pc;
      instr_q[wp_q] <= in_instr;
    end
  end

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign occupancy = count_q;
  assign out_pc    = pc_q[rp_q];

`ifdef IFID_NOP_BUBBLE_EN
  // Empty buffer presents an addi x0,x0,0 bubble to decode.
  assign out_instr = (count_q == 2'd0) ? NOP_INSTR : instr_q[rp_q];
`else
  assign out_instr = instr_q[rp_q];
`endif

  assign Opcode = out_instr[6:0];
  assign Funct3 = out_instr[14:12];
  assign Funct7 = out_instr[31:25];

endmodule
